// File: rtl/snn_pkg.sv
// Shared types and defaults for the spiking-network output classifier.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int N_CLASSES_DEF = 2;
  localparam int WINDOW_DEF    = 15;
  localparam int CNT_W_DEF     = 8;

  // A single class would give $clog2 == 0; keep at least one label bit.
  function automatic int labelWidth(input int nClasses);
    return (nClasses <= 1) ? 1 : $clog2(nClasses);
  endfunction

endpackage

// File: rtl/spike_counter_sat.sv
// Per-channel saturating spike counter with synchronous clear and an overflow-attempt flag.
module spike_counter_sat #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Flags a spike arriving at an already-full counter; the top keeps it sticky.
  assign ovf_o   = en_i && !clear_i && (count_q == CNT_MAX);
  assign count_o = count_q;

endmodule

// File: rtl/spike_count_classifier.sv
// Counts spikes per output channel over a fixed window, then scans for the argmax and
// presents the winning label with a valid/ready handshake.
module spike_count_classifier
  import snn_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int WINDOW    = WINDOW_DEF,
  parameter int LABEL_W   = labelWidth(N_CLASSES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_CLASSES-1:0] spike_in,
  input  logic                 label_ready,
  output logic                 busy,
  output logic                 label_valid,
  output logic [LABEL_W-1:0]   label,
  output logic [CNT_W-1:0]     max_count,
  output logic                 no_spike,
  output logic                 sat
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [LABEL_W-1:0] SCAN_LAST = LABEL_W'(N_CLASSES - 1);

  state_e             state_q;
  logic [WIN_W-1:0]   winCnt_q;
  logic [LABEL_W-1:0] scanIdx_q;
  logic [LABEL_W-1:0] bestIdx_q, bestIdx_d;
  logic [CNT_W-1:0]   bestCnt_q, bestCnt_d;
  logic               labelValid_q;
  logic [LABEL_W-1:0] label_q;
  logic [CNT_W-1:0]   maxCount_q;
  logic               noSpike_q;
  logic               sat_q;

  logic [CNT_W-1:0]     cnt [N_CLASSES];
  logic [N_CLASSES-1:0] ovf;
  logic                 countEn;
  logic                 windowStart;
  logic [CNT_W-1:0]     scanCnt;

  // A window opens from IDLE or straight out of an accepted DONE (back-to-back).
  assign windowStart = start && ((state_q == IDLE) ||
                                 ((state_q == DONE) && label_ready));
  assign countEn     = (state_q == COUNT);

  for (genvar g = 0; g < N_CLASSES; g++) begin : g_chan
    spike_counter_sat #(
      .CNT_W(CNT_W)
    ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .clear_i (windowStart),
      .en_i    (countEn && spike_in[g]),
      .count_o (cnt[g]),
      .ovf_o   (ovf[g])
    );
  end

  assign scanCnt = cnt[scanIdx_q];

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    bestIdx_d = bestIdx_q;
    bestCnt_d = bestCnt_q;
    if (scanIdx_q == '0) begin
      bestIdx_d = '0;
      bestCnt_d = cnt[0];
    end else if (scanCnt > bestCnt_q) begin
      bestIdx_d = scanIdx_q;
      bestCnt_d = scanCnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      winCnt_q     <= '0;
      scanIdx_q    <= '0;
      bestIdx_q    <= '0;
      bestCnt_q    <= '0;
      labelValid_q <= 1'b0;
      label_q      <= '0;
      maxCount_q   <= '0;
      noSpike_q    <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= COUNT;
            winCnt_q <= '0;
            sat_q    <= 1'b0;
          end
        end

        COUNT: begin
          if (|ovf) begin
            sat_q <= 1'b1;
          end
          if (winCnt_q == WIN_LAST) begin
            state_q   <= SCAN;
            scanIdx_q <= '0;
          end else begin
            winCnt_q <= winCnt_q + 1'b1;
          end
        end

        SCAN: begin
          bestIdx_q <= bestIdx_d;
          bestCnt_q <= bestCnt_d;
          if (scanIdx_q == SCAN_LAST) begin
            state_q      <= DONE;
            labelValid_q <= 1'b1;
            label_q      <= bestIdx_d;
            maxCount_q   <= bestCnt_d;
            noSpike_q    <= (bestCnt_d == '0);
          end else begin
            scanIdx_q <= scanIdx_q + 1'b1;
          end
        end

        DONE: begin
          if (label_ready) begin
            labelValid_q <= 1'b0;
            if (start) begin
              state_q  <= COUNT;
              winCnt_q <= '0;
              sat_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == COUNT) || (state_q == SCAN);
  assign label_valid = labelValid_q;
  assign label       = label_q;
  assign max_count   = maxCount_q;
  assign no_spike    = noSpike_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Self-checking bench: table vectors, handshake/reset sequences and randomized windows
// against a counts-and-argmax reference model, on a default and a small saturating instance.
module tb_spike_count_classifier;

  localparam int N   = 2;
  localparam int W   = 15;
  localparam int CW  = 8;
  localparam int NS  = 4;
  localparam int WS  = 12;
  localparam int CWS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start;
  logic [N-1:0] spike_in;
  logic         label_ready;
  logic         busy, label_valid, no_spike, sat;
  logic [0:0]   label;
  logic [CW-1:0] max_count;

  logic          startS;
  logic [NS-1:0] spikeS;
  logic          readyS;
  logic          busyS, validS, noSpikeS, satS;
  logic [1:0]    labelS;
  logic [CWS-1:0] maxS;

  int checks   = 0;
  int failures = 0;
  int spikeMask [64];

  typedef struct {
    int n10;
    int n01;
    int n11;
    int expLabel;
    int expMax;
    int expNs;
    int expSat;
  } vec_t;

  vec_t vecs [7];

  spike_count_classifier #(
    .N_CLASSES(N), .CNT_W(CW), .WINDOW(W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .spike_in(spike_in),
    .label_ready(label_ready), .busy(busy), .label_valid(label_valid),
    .label(label), .max_count(max_count), .no_spike(no_spike), .sat(sat)
  );

  spike_count_classifier #(
    .N_CLASSES(NS), .CNT_W(CWS), .WINDOW(WS)
  ) dutS (
    .clk(clk), .reset(reset), .start(startS), .spike_in(spikeS),
    .label_ready(readyS), .busy(busyS), .label_valid(validS),
    .label(labelS), .max_count(maxS), .no_spike(noSpikeS), .sat(satS)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: count each channel over the window with saturation, then take the
  // highest count, lowest channel winning ties.
  function automatic void model(input int nCls, input int cntW, input int win,
                                output int lab, output int mx, output int ns, output int st);
    int cnt [16];
    int cmax;
    cmax = (1 << cntW) - 1;
    st = 0;
    for (int c = 0; c < 16; c++) cnt[c] = 0;
    for (int w = 0; w < win; w++)
      for (int c = 0; c < nCls; c++)
        if (((spikeMask[w] >> c) & 1) == 1) begin
          if (cnt[c] == cmax) st = 1;
          else cnt[c]++;
        end
    lab = 0;
    mx  = cnt[0];
    for (int c = 1; c < nCls; c++)
      if (cnt[c] > mx) begin
        lab = c;
        mx  = cnt[c];
      end
    ns = (mx == 0) ? 1 : 0;
  endfunction

  // Runs one window on the default instance; if chained, start was already given in DONE.
  task automatic applyStimulus(input bit chained, input int expLabel, input int expMax,
                               input int expNs, input int expSat, input bit noisyStart);
    int nEdge;
    int busyCycles;
    bit gotValid;
    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
    end
    nEdge = -1;
    busyCycles = 0;
    gotValid = 1'b0;
    while (!gotValid && nEdge < 60) begin
      @(negedge clk);
      nEdge++;
      label_ready = 1'b0;
      start = noisyStart ? 1'($urandom) : 1'b0;
      if (label_valid) begin
        gotValid = 1'b1;
      end else begin
        if (busy) busyCycles++;
        spike_in = (nEdge < W) ? 2'(spikeMask[nEdge]) : 2'($urandom);
      end
    end
    start = 1'b0;
    checkOutput("latency", nEdge, W + N);
    checkOutput("busy_cycles", busyCycles, W + N);
    checkOutput("label", int'(label), expLabel);
    checkOutput("max_count", int'(max_count), expMax);
    checkOutput("no_spike", int'(no_spike), expNs);
    checkOutput("sat", int'(sat), expSat);
  endtask

  // Holds backpressure for a while, then accepts (optionally with a back-to-back start).
  task automatic acceptResult(input int hold, input bit withStart,
                              input int expLabel, input int expMax);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      spike_in = 2'($urandom);
      checkOutput("hold_valid", int'(label_valid), 1);
      checkOutput("hold_label", int'(label), expLabel);
      checkOutput("hold_max", int'(max_count), expMax);
    end
    label_ready = 1'b1;
    start = withStart;
    if (!withStart) begin
      @(negedge clk);
      label_ready = 1'b0;
      checkOutput("accept_valid_low", int'(label_valid), 0);
      checkOutput("accept_idle", int'(busy), 0);
    end
  endtask

  task automatic applySatStimulus(input int expLabel, input int expMax,
                                  input int expNs, input int expSat);
    int nEdge;
    bit gotValid;
    @(negedge clk);
    startS = 1'b1;
    nEdge = -1;
    gotValid = 1'b0;
    while (!gotValid && nEdge < 60) begin
      @(negedge clk);
      nEdge++;
      startS = 1'b0;
      if (validS) gotValid = 1'b1;
      else spikeS = (nEdge < WS) ? 4'(spikeMask[nEdge]) : 4'($urandom);
    end
    checkOutput("s_latency", nEdge, WS + NS);
    checkOutput("s_label", int'(labelS), expLabel);
    checkOutput("s_max_count", int'(maxS), expMax);
    checkOutput("s_no_spike", int'(noSpikeS), expNs);
    checkOutput("s_sat", int'(satS), expSat);
    readyS = 1'b1;
    @(negedge clk);
    readyS = 1'b0;
    checkOutput("s_accept", int'(validS), 0);
  endtask

  task automatic fillMask(input vec_t v);
    for (int w = 0; w < 64; w++) begin
      if (w < v.n10) spikeMask[w] = 2;
      else if (w < v.n10 + v.n01) spikeMask[w] = 1;
      else if (w < v.n10 + v.n01 + v.n11) spikeMask[w] = 3;
      else spikeMask[w] = 0;
    end
  endtask

  initial begin
    int lab, mx, ns, st, labB, mxB, nsB, stB;
    int validSeen;

    vecs[0] = '{9, 4, 0, 1, 9, 0, 0};
    vecs[1] = '{0, 0, 6, 0, 6, 0, 0};
    vecs[2] = '{0, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{2, 5, 3, 0, 8, 0, 0};
    vecs[4] = '{0, 0, 15, 0, 15, 0, 0};
    vecs[5] = '{7, 0, 0, 1, 7, 0, 0};
    vecs[6] = '{0, 1, 0, 0, 1, 0, 0};

    reset = 1'b1; start = 1'b0; spike_in = '0; label_ready = 1'b0;
    startS = 1'b0; spikeS = '0; readyS = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(label_valid), 0);
    checkOutput("rst_label", int'(label), 0);
    checkOutput("rst_max", int'(max_count), 0);
    checkOutput("rst_no_spike", int'(no_spike), 0);
    checkOutput("rst_sat", int'(sat), 0);
    checkOutput("rst_s_valid", int'(validS), 0);

    for (int i = 0; i < 7; i++) begin
      fillMask(vecs[i]);
      applyStimulus(1'b0, vecs[i].expLabel, vecs[i].expMax, vecs[i].expNs,
                    vecs[i].expSat, (i % 2) == 1);
      acceptResult((i == 0) ? 5 : 0, 1'b0, vecs[i].expLabel, vecs[i].expMax);
    end

    // Backpressure then back-to-back window
    for (int w = 0; w < 64; w++) spikeMask[w] = $urandom_range(0, 3);
    model(N, CW, W, lab, mx, ns, st);
    applyStimulus(1'b0, lab, mx, ns, st, 1'b0);
    acceptResult(5, 1'b1, lab, mx);
    for (int w = 0; w < 64; w++) spikeMask[w] = (w % 3 == 0) ? 1 : 0;
    model(N, CW, W, labB, mxB, nsB, stB);
    applyStimulus(1'b1, labB, mxB, nsB, stB, 1'b1);
    acceptResult(2, 1'b0, labB, mxB);

    // Reset in the middle of COUNT
    for (int w = 0; w < 64; w++) spikeMask[w] = 2;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      start = 1'b0;
      spike_in = 2'(spikeMask[e]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_valid", int'(label_valid), 0);
    checkOutput("midrst_label", int'(label), 0);
    checkOutput("midrst_max", int'(max_count), 0);
    checkOutput("midrst_no_spike", int'(no_spike), 0);
    checkOutput("midrst_sat", int'(sat), 0);
    validSeen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      spike_in = 2'($urandom);
      if (label_valid || busy) validSeen++;
    end
    checkOutput("midrst_stays_idle", validSeen, 0);
    for (int w = 0; w < 64; w++) spikeMask[w] = $urandom_range(0, 3);
    model(N, CW, W, lab, mx, ns, st);
    applyStimulus(1'b0, lab, mx, ns, st, 1'b1);
    acceptResult(0, 1'b0, lab, mx);

    // Randomized windows with varying density
    for (int r = 0; r < 8; r++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int w = 0; w < 64; w++)
        spikeMask[w] = (($urandom_range(0, 99) < dens) ? 1 : 0) |
                       (($urandom_range(0, 99) < 100 - dens) ? 2 : 0);
      model(N, CW, W, lab, mx, ns, st);
      applyStimulus(1'b0, lab, mx, ns, st, r[0]);
      acceptResult(r % 3, 1'b0, lab, mx);
    end

    // Small instance: saturation
    for (int w = 0; w < 64; w++) spikeMask[w] = 4;
    applySatStimulus(2, 7, 0, 1);
    for (int r = 0; r < 5; r++) begin
      for (int w = 0; w < 64; w++) spikeMask[w] = $urandom_range(0, 15) & $urandom_range(0, 15);
      model(NS, CWS, WS, lab, mx, ns, st);
      applySatStimulus(lab, mx, ns, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
